// File: rtl/riscv_prog_loader_pkg.sv
// Shared definitions for the riscv program loader: FSM encoding and frame geometry.
// Both the FSM and the byte packer import this package.
package riscv_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } loader_state_t;

  localparam int HDR_BYTES  = 2;
  localparam int LEN_W      = HDR_BYTES * 8;
  localparam int WORD_BYTES = 4;
  localparam int LANE_W     = $clog2(WORD_BYTES);

  // A new frame may only be requested once the previous one has settled.
  function automatic logic accepts_start(input loader_state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
  endfunction

endpackage

// File: rtl/riscv_prog_loader_if.sv
// Host byte stream plus instruction-memory write port seen by the loader.
// The master side is the loader: it drives in_ready and the memory write port.
interface riscv_prog_loader_if #(
  parameter int ADDR_W = 6
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/riscv_prog_loader_byte_packer.sv
// Assembles four little-endian bytes into a 32-bit word and tracks the current lane.
// clear restarts the lane counter at the beginning of every word.
module byte_packer
  import riscv_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        lane_last
);

  logic [LANE_W-1:0]     lane_reg;
  logic [31:0]           word_reg;
  logic [WORD_BYTES-1:0] lane_we;

  genvar gi;
  generate
    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      assign lane_we[gi] = byte_valid && (lane_reg == LANE_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_reg <= '0;
      word_reg <= '0;
    end else begin
      if (clear) begin
        lane_reg <= '0;
      end else if (byte_valid) begin
        lane_reg <= lane_reg + LANE_W'(1);
      end
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (lane_we[i]) begin
          word_reg[i*8 +: 8] <= byte_data;
        end
      end
    end
  end

  assign word      = word_reg;
  assign lane_last = (lane_reg == LANE_W'(WORD_BYTES - 1));

endmodule

// File: rtl/riscv_prog_loader.sv
// Receives a length-prefixed program over a byte stream, writes it into instruction
// memory and releases the core from reset only after a complete, valid load.
module riscv_prog_loader
  import riscv_loader_pkg::*;
#(
  parameter int MEM_WORDS = 64,
  parameter int ADDR_W    = 6
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  riscv_prog_loader_if.master bus,
  output logic                cpu_rst,
  output logic                busy,
  output logic                done,
  output logic                err
);

  loader_state_t     state_reg, state_next;
  logic [LEN_W-1:0]  count_reg;
  logic [ADDR_W-1:0] index_reg;

  logic              xfer;
  logic [LEN_W-1:0]  len_full;
  logic              last_word;
  logic              packer_clear;
  logic              packer_valid;
  logic [31:0]       packed_word;
  logic              lane_last;

  assign xfer      = bus.in_valid && bus.in_ready;
  assign len_full  = {bus.in_data, count_reg[7:0]};
  assign last_word = (LEN_W'(index_reg) == (count_reg - LEN_W'(1)));

  // Lane counter restarts whenever a new word begins: after the header and after each write.
  assign packer_clear = ((state_reg == ST_LEN_HI) && xfer) || (state_reg == ST_WRITE);
  assign packer_valid = (state_reg == ST_DATA) && xfer;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (packer_clear),
    .byte_valid (packer_valid),
    .byte_data  (bus.in_data),
    .word       (packed_word),
    .lane_last  (lane_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
      index_reg <= '0;
    end else begin
      if (accepts_start(state_reg) && start) begin
        index_reg <= '0;
      end
      if ((state_reg == ST_LEN_LO) && xfer) begin
        count_reg[7:0] <= bus.in_data;
      end
      if ((state_reg == ST_LEN_HI) && xfer) begin
        count_reg[15:8] <= bus.in_data;
      end
      if ((state_reg == ST_WRITE) && !last_word) begin
        index_reg <= index_reg + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    bus.in_ready  = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = index_reg;
    bus.mem_wdata = packed_word;
    busy          = 1'b0;
    done          = 1'b0;
    err           = 1'b0;
    cpu_rst       = 1'b1;

    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        bus.in_ready = 1'b1;
        busy         = 1'b1;
        if (xfer) state_next = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        bus.in_ready = 1'b1;
        busy         = 1'b1;
        // Reject empty frames and frames that would overrun memory before any write happens.
        if (xfer) begin
          if ((len_full == '0) || (len_full > LEN_W'(MEM_WORDS))) begin
            state_next = ST_ERR;
          end else begin
            state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        bus.in_ready = 1'b1;
        busy         = 1'b1;
        if (xfer && lane_last) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        bus.mem_we = 1'b1;
        busy       = 1'b1;
        state_next = last_word ? ST_DONE : ST_DATA;
      end
      ST_DONE: begin
        done    = 1'b1;
        cpu_rst = 1'b0;
        if (start) state_next = ST_LEN_LO;
      end
      ST_ERR: begin
        err = 1'b1;
        if (start) state_next = ST_LEN_LO;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_riscv_prog_loader.sv
// Self-checking bench for riscv_prog_loader: expected memory writes are queued as frames
// are sent and checked against every mem_we pulse; status outputs are checked per scenario.
module tb_riscv_prog_loader;

  localparam int MEM_WORDS = 64;
  localparam int ADDR_W    = 6;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk;
  logic rst;
  logic start;
  logic cpu_rst, busy, done, err;

  int n_checks  = 0;
  int n_fail    = 0;
  int we_pulses = 0;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] frame_words[$];

  riscv_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  riscv_prog_loader #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus),
    .cpu_rst (cpu_rst),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (rst && bus.mem_we) begin
      we_pulses++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write addr=%0d data=%h expected none", bus.mem_addr, bus.mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.mem_addr !== mon_e.addr || bus.mem_wdata !== mon_e.data) begin
          n_fail++;
          $display("FAIL write got addr=%0d data=%h expected addr=%0d data=%h",
                   bus.mem_addr, bus.mem_wdata, mon_e.addr, mon_e.data);
        end else begin
          $display("write addr=%0d data=%h ok", bus.mem_addr, bus.mem_wdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    @(negedge clk);
    bus.in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  // Returns just after the rising edge on which the byte is transferred; in_valid stays high.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ready_timeout byte=%h waited=%0d cycles expected ready", b, guard);
    end
    @(posedge clk);
  endtask

  task automatic send_frame(input int gap);
    wr_t e;
    int  n;
    logic [31:0] w;
    n = frame_words.size();
    send_byte(n[7:0]);
    if (gap > 0) idle_cycles(gap);
    send_byte(n[15:8]);
    for (int i = 0; i < n; i++) begin
      w      = frame_words[i];
      e.addr = ADDR_W'(i);
      e.data = w;
      exp_q.push_back(e);
      for (int k = 0; k < 4; k++) begin
        if (gap > 0) idle_cycles(gap);
        send_byte(w[k*8 +: 8]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    n_checks++;
    if ({cpu_rst, bus.in_ready, bus.mem_we, busy, done, err} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_outputs got cpu_rst,rdy,we,busy,done,err=%b expected 100000",
               {cpu_rst, bus.in_ready, bus.mem_we, busy, done, err});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({cpu_rst, busy, done, err} !== 4'b1000) begin
      n_fail++;
      $display("FAIL idle_after_reset got cpu_rst,busy,done,err=%b expected 1000",
               {cpu_rst, busy, done, err});
    end
    $display("reset test complete");
  endtask

  task automatic test_basic();
    int p0;
    p0 = we_pulses;
    pulse_start();
    n_checks++;
    if ({busy, bus.in_ready, cpu_rst, done} !== 4'b1110) begin
      n_fail++;
      $display("FAIL basic_len_lo got busy,rdy,cpu_rst,done=%b expected 1110",
               {busy, bus.in_ready, cpu_rst, done});
    end
    frame_words = '{32'h00527863, 32'h00627263};
    send_frame(0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 6'd1) begin
      n_fail++;
      $display("FAIL basic_latency got we=%b addr=%0d expected we=1 addr=1", bus.mem_we, bus.mem_addr);
    end
    @(negedge clk);
    n_checks++;
    if ({done, cpu_rst, busy, err} !== 4'b1000) begin
      n_fail++;
      $display("FAIL basic_done got done,cpu_rst,busy,err=%b expected 1000", {done, cpu_rst, busy, err});
    end
    n_checks++;
    if (we_pulses - p0 != 2 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_pulses got %0d pending=%0d expected 2 pending=0", we_pulses - p0, exp_q.size());
    end
    $display("basic load complete");
  endtask

  task automatic test_backpressure();
    int p0;
    p0 = we_pulses;
    pulse_start();
    frame_words = '{32'h00527863, 32'h00627263};
    send_frame(3);
    idle_cycles(2);
    n_checks++;
    if ({done, cpu_rst} !== 2'b10 || we_pulses - p0 != 2 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL backpressure got done=%b cpu_rst=%b pulses=%0d pending=%0d expected done=1 cpu_rst=0 pulses=2 pending=0",
               done, cpu_rst, we_pulses - p0, exp_q.size());
    end
    $display("backpressure load complete");
  endtask

  task automatic test_zero_count();
    int p0;
    p0 = we_pulses;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    @(negedge clk);
    bus.in_valid = 1'b1;
    n_checks++;
    if ({err, cpu_rst, bus.in_ready, busy, done} !== 5'b11000) begin
      n_fail++;
      $display("FAIL zero_count got err,cpu_rst,rdy,busy,done=%b expected 11000",
               {err, cpu_rst, bus.in_ready, busy, done});
    end
    idle_cycles(2);
    n_checks++;
    if (we_pulses != p0 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_count_hold got pulses=%0d err=%b expected pulses=0 err=1", we_pulses - p0, err);
    end
    $display("zero count test complete");
  endtask

  task automatic test_oversize();
    int p0;
    p0 = we_pulses;
    pulse_start();
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_clears_err got err=%b busy=%b expected err=0 busy=1", err, busy);
    end
    send_byte(8'h41);
    send_byte(8'h00);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++;
    if ({err, cpu_rst, busy} !== 3'b110 || we_pulses != p0) begin
      n_fail++;
      $display("FAIL oversize got err,cpu_rst,busy=%b pulses=%0d expected 110 pulses=0",
               {err, cpu_rst, busy}, we_pulses - p0);
    end
    pulse_start();
    frame_words = '{32'hdeadbeef, 32'h00000013, 32'hcafef00d};
    send_frame(0);
    idle_cycles(2);
    n_checks++;
    if ({done, cpu_rst, err} !== 3'b100 || we_pulses - p0 != 3 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL oversize_recover got done,cpu_rst,err=%b pulses=%0d expected 100 pulses=3",
               {done, cpu_rst, err}, we_pulses - p0);
    end
    $display("oversize test complete");
  endtask

  task automatic test_reset_mid_frame();
    int p0;
    p0 = we_pulses;
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'haa);
    send_byte(8'hbb);
    #2;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    n_checks++;
    if ({cpu_rst, bus.in_ready, bus.mem_we, busy, done, err} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_mid_frame got cpu_rst,rdy,we,busy,done,err=%b expected 100000",
               {cpu_rst, bus.in_ready, bus.mem_we, busy, done, err});
    end
    idle_cycles(3);
    rst = 1'b1;
    idle_cycles(3);
    n_checks++;
    if (we_pulses != p0 || cpu_rst !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_frame_after got pulses=%0d cpu_rst=%b done=%b expected 0 1 0",
               we_pulses - p0, cpu_rst, done);
    end
    $display("reset mid-frame test complete");
  endtask

  task automatic test_start_handling();
    wr_t e;
    int  p0;
    p0 = we_pulses;
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    e.addr = '0;
    e.data = 32'h12345678;
    exp_q.push_back(e);
    send_byte(8'h78);
    send_byte(8'h56);
    pulse_start();
    n_checks++;
    if (busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL start_while_busy got busy=%b rdy=%b expected 1 1", busy, bus.in_ready);
    end
    send_byte(8'h34);
    send_byte(8'h12);
    idle_cycles(2);
    n_checks++;
    if ({done, cpu_rst} !== 2'b10 || we_pulses - p0 != 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL start_busy_done got done=%b cpu_rst=%b pulses=%0d expected 1 0 1",
               done, cpu_rst, we_pulses - p0);
    end
    pulse_start();
    n_checks++;
    if ({cpu_rst, done, busy} !== 3'b101) begin
      n_fail++;
      $display("FAIL start_after_done got cpu_rst,done,busy=%b expected 101", {cpu_rst, done, busy});
    end
    $display("start handling test complete");
  endtask

  initial begin
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_count();
    test_oversize();
    test_reset_mid_frame();
    test_start_handling();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_writes got %0d expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
